// File: rtl/sparse_dot_engine.sv
// rtl/sparse_dot_engine.sv - sparse dot-product engine with dequantised weight memory,
// zero-skipping and a saturating accumulator behind a two-stage beat pipeline.
module sparse_dot_engine #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8,
  parameter int LW    = 8,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       dq_scale,
  input  logic [3:0]       dq_offset,
  input  logic             mem_write_en,
  input  logic [AW-1:0]    mem_write_idx,
  input  logic [DW-1:0]    mem_write_val,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [LW-1:0]    length,
  input  logic             act_valid,
  input  logic [DW-1:0]    act_data,
  output logic             act_ready,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result_out,
  output logic [LW-1:0]    skip_count,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [AW-1:0]    base_q, base_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    idx_q, idx_d;
  logic [LW-1:0]    skip_q, skip_d;
  logic             s1_valid_q, s1_valid_d;
  logic [DW-1:0]    s1_w_q, s1_w_d;
  logic [DW-1:0]    s1_act_q, s1_act_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             accept;
  logic [AW-1:0]    rd_addr;
  logic [DW-1:0]    w_sub;
  logic [DW+3:0]    dq;
  logic [2*DW+3:0]  prod;
  logic [ACC_W:0]   sum;
  logic             skip_beat;

  // Stage-2 datapath works on the raw weight captured in stage 1.
  assign accept    = (state_q == RUN) && act_valid;
  assign rd_addr   = base_q + idx_q[AW-1:0];
  assign w_sub     = (s1_w_q >= DW'(dq_offset)) ? (s1_w_q - DW'(dq_offset)) : '0;
  assign dq        = (DW+4)'(w_sub) * (DW+4)'(dq_scale);
  assign prod      = (2*DW+4)'(dq) * (2*DW+4)'(s1_act_q);
  assign sum       = {1'b0, acc_q} + (ACC_W+1)'(prod);
  assign skip_beat = (dq == '0) || (s1_act_q == '0);

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    skip_d     = skip_q;
    s1_valid_d = accept;
    s1_w_d     = s1_w_q;
    s1_act_d   = s1_act_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    if (mem_write_en) mem_d[mem_write_idx] = mem_write_val;

    if (s1_valid_q) begin
      if (skip_beat) begin
        skip_d = skip_q + LW'(1);
      end else if (sum[ACC_W]) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          len_d   = length;
          idx_d   = '0;
          acc_d   = '0;
          skip_d  = '0;
          ovf_d   = 1'b0;
          state_d = (length == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          // mem_q is read before this edge's write lands, so same-address reads see old data.
          s1_w_d   = mem_q[rd_addr];
          s1_act_d = act_data;
          idx_d    = idx_q + LW'(1);
          if (idx_q == len_q - LW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      base_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      skip_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_w_q     <= '0;
      s1_act_q   <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      base_q     <= base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      skip_q     <= skip_d;
      s1_valid_q <= s1_valid_d;
      s1_w_q     <= s1_w_d;
      s1_act_q   <= s1_act_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign act_ready  = (state_q == RUN);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign result_out = acc_q;
  assign skip_count = skip_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/sparse_dot_engine.md
# sparse_dot_engine

Parametrised sparse dot-product engine, the next generation of the single-shot `gpu_top` inference pipeline. It holds a quantised weight memory and dequantises each weight as (w − offset) × scale. On `start` it streams a vector of activations against consecutive weights and accumulates the products with zero-skipping and saturation. It returns one accumulated result per job with a done pulse, a skip count and an overflow flag.

## Interface
- `DEPTH`, 16: weight memory entries; power of two.
- `AW`, 4: weight address width, log2(DEPTH).
- `DW`, 8: weight and activation width, unsigned.
- `LW`, 8: job length width.
- `ACC_W`, 32: accumulator and result width; must be at least 2·DW+4.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `dq_scale`  in  4  dequant scale, unsigned; static while busy.
- `dq_offset`  in  4  dequant offset, unsigned; static while busy.
- `mem_write_en`  in  1  weight write strobe.
- `mem_write_idx`  in  AW  weight write address.
- `mem_write_val`  in  DW  weight write data.
- `start`  in  1  job start; one-cycle pulse, honoured in IDLE only.
- `base_addr`  in  AW  first weight address; sampled with `start`.
- `length`  in  LW  number of activations in the job; sampled with `start`.
- `act_valid`  in  1  activation beat valid.
- `act_data`  in  DW  activation value.
- `act_ready`  out  1  engine accepts a beat.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle pulse; result is valid.
- `result_out`  out  ACC_W  accumulated sum; held until the next accepted start.
- `skip_count`  out  LW  number of beats skipped in the last job.
- `overflow`  out  1  sticky per job; accumulator saturated.

## Operation
- Weight memory:
  - DEPTH×DW register array, cleared to 0 by `rst`.
  - Write on a clock edge when `mem_write_en` is 1. Writes are legal in any state.
  - A read and a write to the same address on the same edge: the read returns the old value.
- Dequant: dq = (w ≥ offset ? w − offset : 0) × scale. The subtraction saturates at 0. dq width is DW+4.
- Product: p = dq × act, 2·DW+4 bits, zero-extended to ACC_W.
- Zero skip: if dq == 0 or act == 0, the accumulator is not updated and `skip_count` increments.
- Accumulation saturates: if acc + p exceeds 2^ACC_W − 1, acc becomes all ones and `overflow` sets.
- States:
  - IDLE: `act_ready`=0. On `start`: latch base/length, clear acc, `skip_count` and `overflow`. Go to RUN, or to DRAIN if length == 0.
  - RUN: `act_ready`=1. Each accepted beat (`act_valid` && `act_ready`) reads weight[(base + k) mod DEPTH], k = 0..length−1; the address wraps past DEPTH−1 to 0. Stage-1 registers the raw weight and the activation. The final beat moves the state to DRAIN.
  - DRAIN: `act_ready`=0. Stage-2 retires the last beat into acc, `done` is set to 1, and the state returns to IDLE.
- Stage-2 retires each stage-1 beat on the edge after its acceptance, so back-to-back beats sustain 1 beat per cycle.
- `start` while not in IDLE is ignored.
- `act_valid` outside RUN is ignored; no beat is consumed.
- `rst` mid-job: state goes to IDLE, every output goes to 0, memory is cleared, and in-flight beats are discarded.

## Timing
- Reset values: `act_ready`=0, `busy`=0, `done`=0, `result_out`=0, `skip_count`=0, `overflow`=0. All memory entries are 0.
- `busy` is 1 from the edge that accepts `start` up to and including the edge that sets `done`. It is 0 in the cycle `done` is high.
- Start at edge S gives `act_ready`=1 in the cycle after S.
- Last beat accepted at edge E gives `done` high in the cycle after edge E+1. `result_out`, `skip_count` and `overflow` are final in that same cycle.
- With length == 0, start at S gives `done` in the cycle after S+1 and `result_out` = 0.
- Gaps in `act_valid` stall the job without loss; the accumulator and index hold.
- `done` lasts exactly one cycle. The earliest next `start` is honoured in the `done` cycle (state is IDLE).

## Test plan
- Basic job. Setup: scale=2, offset=0; weights 6@0, 10@1, 0@2. Start base=0, length=3, acts 5,3,9 back-to-back. Required: `result_out`=120, `skip_count`=1, `overflow`=0, `done` 2 edges after the last beat.
- Address wrap. Setup: weights 4@15, 7@0. Start base=15, length=2, acts 1,1, scale=1. Required: result=11, skips=0.
- Offset saturation. Setup: weight 3@5, offset=5, scale=3. Act 9 at base=5, length=1. Required: result=0, skips=1. Then a zero activation against weight 6, scale 2: skips=1.
- Overflow. Setup: ACC_W=20; weight 255@0, scale=15, offset=0. Length=2, acts 255,255. The true sum is 1950750. Required: result=0xFFFFF, `overflow`=1.
- Backpressure, start rules and zero length. `act_valid` is low for 3 cycles mid-job; the result must be identical to the no-gap run. A `start` pulsed while busy is ignored. length=0 gives `done` with result 0 and `act_ready` never high.
- Reset mid-job. Assert `rst` after 1 beat of a length-4 job. Required: all outputs 0 and memory read back as 0. A fresh job after reset runs correctly.
